// File: rtl/pkt_capture_buffer.sv
// -----------------------------------------------------------------------------
// pkt_capture_buffer
//
// Captures every packet arriving on the MAC stream into a circular capture
// RAM. The packet is then committed or discarded on the match controller's
// clear/inc_addr flags. A committed packet advances commit_ptr and stays
// readable by the host. An unmatched, errored or truncated packet is rolled
// back so that its space is reused.
//
// Optional feature macro: PKT_CAPTURE_HEADER_EN
//   When defined, one word is reserved at the start of every packet. On
//   commit, a header {16'hCAFE, len[15:0]} is written into that word.
//   When undefined, packet data starts directly at the packet start address.
//
// Ports
//   clk, n_rst           : clock, asynchronous active-low reset
//   in_valid/sop/eop/err : MAC stream beat qualifiers
//   in_data              : MAC stream data
//   clear, inc_addr      : controller decision flags
//   rd_ptr               : host read pointer (oldest unread word)
//   mem_wr/addr/wdata    : registered capture RAM write port
//   commit_ptr           : one past the last committed word
//   pkts_committed       : committed packet count (wraps)
//   pkts_dropped         : discarded packet count (saturates)
//   overflow             : sticky, a packet hit a full ring
// -----------------------------------------------------------------------------
module pkt_capture_buffer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_error,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic              inc_addr,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] commit_ptr,
    output logic [31:0]       pkts_committed,
    output logic [15:0]       pkts_dropped,
    output logic              overflow
);

`ifdef PKT_CAPTURE_HEADER_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] HDR_OFF = ADDR_W'(HDR_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_PENDING,
        S_DECIDE,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   start_ptr_q, start_ptr_d;
    logic [15:0]         len_q, len_d;
    logic                trunc_q, trunc_d;
    logic                foreign_q, foreign_d;   // a sop seen while awaiting a decision; its eop is still pending
    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   commit_ptr_q, commit_ptr_d;
    logic [31:0]         committed_q, committed_d;
    logic [15:0]         dropped_q, dropped_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [1:0]          drop_inc;
    logic [16:0]         drop_sum;
    logic [ADDR_W-1:0]   base_ptr;
    logic [ADDR_W-1:0]   data_ptr;
    logic [ADDR_W-1:0]   data_ptr_p1;
    logic [ADDR_W-1:0]   base_ptr_p1;
    logic [ADDR_W-1:0]   wr_ptr_p1;
    logic                sop_full;
    logic                decided;

    // Pointer arithmetic, kept at ADDR_W bits so that it wraps around the ring.
    // A sop inside CAPTURE first rolls back, so the new packet starts at start_ptr.
    always_comb begin
        base_ptr    = (state_q == S_CAPTURE) ? start_ptr_q : wr_ptr_q;
        data_ptr    = base_ptr + HDR_OFF;
        data_ptr_p1 = data_ptr + PTR_ONE;
        base_ptr_p1 = base_ptr + PTR_ONE;
        wr_ptr_p1   = wr_ptr_q + PTR_ONE;
        // The header slot counts toward the full check as well as the first data word.
        sop_full    = (data_ptr_p1 == rd_ptr) || ((HDR_WORDS != 0) && (base_ptr_p1 == rd_ptr));
        decided     = (state_q == S_DECIDE) && (inc_addr || clear);
    end

    // Datapath next-state logic.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        len_d        = len_q;
        trunc_d      = trunc_q;
        foreign_d    = foreign_q;
        overflow_d   = overflow_q;
        commit_ptr_d = commit_ptr_q;
        committed_d  = committed_q;
        drop_inc     = 2'd0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE, S_CAPTURE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        // A sop with no eop on the previous packet drops the previous packet.
                        if (state_q == S_CAPTURE) begin
                            drop_inc = drop_inc + 2'd1;
                        end
                        start_ptr_d = base_ptr;
                        wr_ptr_d    = base_ptr;
                        len_d       = 16'd0;
                        trunc_d     = 1'b0;
                        foreign_d   = 1'b0;
                        if (in_error) begin
                            drop_inc = drop_inc + 2'd1;
                        end else if (sop_full) begin
                            trunc_d    = 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            mem_wr_d    = 1'b1;
                            mem_addr_d  = data_ptr;
                            mem_wdata_d = in_data;
                            wr_ptr_d    = data_ptr_p1;
                            len_d       = 16'd1;
                        end
                    end else if (state_q == S_CAPTURE) begin
                        if (in_error) begin
                            wr_ptr_d = start_ptr_q;
                            drop_inc = 2'd1;
                        end else if (!trunc_q) begin
                            if (wr_ptr_p1 == rd_ptr) begin
                                // Once truncated, every remaining beat of the packet is dropped.
                                trunc_d    = 1'b1;
                                overflow_d = 1'b1;
                            end else begin
                                mem_wr_d    = 1'b1;
                                mem_addr_d  = wr_ptr_q;
                                mem_wdata_d = in_data;
                                wr_ptr_d    = wr_ptr_p1;
                                len_d       = len_q + 16'd1;
                            end
                        end
                    end
                end
            end
            S_PENDING, S_DECIDE: begin
                // A packet starting before the decision is never captured.
                if (in_valid && in_sop) begin
                    drop_inc  = 2'd1;
                    foreign_d = !in_eop;
                end else if (in_valid && in_eop) begin
                    foreign_d = 1'b0;
                end
                if (state_q == S_DECIDE) begin
                    if (inc_addr && !trunc_q) begin
                        commit_ptr_d = wr_ptr_q;
                        committed_d  = committed_q + 32'd1;
`ifdef PKT_CAPTURE_HEADER_EN
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = start_ptr_q;
                        mem_wdata_d = DATA_W'({16'hCAFE, len_q});
`endif
                    end else if (clear || inc_addr) begin
                        wr_ptr_d = start_ptr_q;
                        drop_inc = drop_inc + 2'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (in_valid && in_eop) begin
                    foreign_d = 1'b0;
                end
            end
            default: begin
                foreign_d = 1'b0;
            end
        endcase

        drop_sum  = {1'b0, dropped_q} + 17'(drop_inc);
        dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_CAPTURE: begin
                if (in_valid) begin
                    if (in_sop || state_q == S_CAPTURE) begin
                        if (in_error) begin
                            state_d = S_IDLE;
                        end else if (in_eop) begin
                            state_d = S_PENDING;
                        end else begin
                            state_d = S_CAPTURE;
                        end
                    end
                end
            end
            S_PENDING: begin
                if (clear) begin
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (decided) begin
                    state_d = foreign_d ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (in_valid && in_eop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            len_q        <= '0;
            trunc_q      <= 1'b0;
            foreign_q    <= 1'b0;
            overflow_q   <= 1'b0;
            commit_ptr_q <= '0;
            committed_q  <= '0;
            dropped_q    <= '0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            start_ptr_q  <= start_ptr_d;
            len_q        <= len_d;
            trunc_q      <= trunc_d;
            foreign_q    <= foreign_d;
            overflow_q   <= overflow_d;
            commit_ptr_q <= commit_ptr_d;
            committed_q  <= committed_d;
            dropped_q    <= dropped_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        mem_wr         = mem_wr_q;
        mem_addr       = mem_addr_q;
        mem_wdata      = mem_wdata_q;
        commit_ptr     = commit_ptr_q;
        pkts_committed = committed_q;
        pkts_dropped   = dropped_q;
        overflow       = overflow_q;
    end

endmodule

// File: tb/tb_pkt_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_pkt_capture_buffer
//
// Drives whole packets plus controller decisions into pkt_capture_buffer on
// a small ring (ADDR_W = 3). Each packet outcome is predicted from ring
// occupancy arithmetic: free words, truncation, expected writes and counters.
// The prediction is then compared with the observed RAM writes and status
// outputs. Honours PKT_CAPTURE_HEADER_EN when defined.
// -----------------------------------------------------------------------------
module tb_pkt_capture_buffer;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int N  = 1 << AW;
`ifdef PKT_CAPTURE_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic          in_valid, in_sop, in_eop, in_error;
    logic [DW-1:0] in_data;
    logic          clear, inc_addr;
    logic [AW-1:0] rd_ptr;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] commit_ptr;
    logic [31:0]   pkts_committed;
    logic [15:0]   pkts_dropped;
    logic          overflow;

    always #5 clk = ~clk;

    pkt_capture_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_error       (in_error),
        .in_data        (in_data),
        .clear          (clear),
        .inc_addr       (inc_addr),
        .rd_ptr         (rd_ptr),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .commit_ptr     (commit_ptr),
        .pkts_committed (pkts_committed),
        .pkts_dropped   (pkts_dropped),
        .overflow       (overflow)
    );

    int tests = 0;
    int fails = 0;

    // Observed RAM writes.
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    always @(negedge clk) begin
        if (n_rst === 1'b1 && mem_wr === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
        end
    end

    // Reference state.
    int            m_commit, m_committed, m_dropped, m_rd;
    bit            m_ovf;
    int            ex_addr[$];
    logic [DW-1:0] ex_data[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
        in_data = '0; clear = 1'b0; inc_addr = 1'b0;
    endtask

    task automatic set_rd(input int v);
        m_rd   = v % N;
        rd_ptr = AW'(m_rd);
    endtask

    task automatic do_reset();
        idle_inputs();
        n_rst = 1'b0;
        set_rd(0);
        tick(); tick();
        n_rst = 1'b1;
        tick();
        obs_addr.delete(); obs_data.delete();
        ex_addr.delete();  ex_data.delete();
        m_commit = 0; m_committed = 0; m_dropped = 0; m_ovf = 1'b0;
    endtask

    task automatic check_status(input string tag);
        int n;
        check({tag, "_nwr"}, 64'(obs_addr.size()), 64'(ex_addr.size()));
        n = (obs_addr.size() < ex_addr.size()) ? obs_addr.size() : ex_addr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, 64'(obs_addr[i]), 64'(ex_addr[i]));
            check({tag, "_data"}, 64'(obs_data[i]), 64'(ex_data[i]));
        end
        check({tag, "_commit_ptr"}, 64'(commit_ptr), 64'(m_commit));
        check({tag, "_committed"}, 64'(pkts_committed), 64'(m_committed));
        check({tag, "_dropped"}, 64'(pkts_dropped), 64'(m_dropped));
        check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
        $display("[TB] %s: %0d writes, commit_ptr=%0d committed=%0d dropped=%0d overflow=%0d",
                 tag, obs_addr.size(), commit_ptr, pkts_committed, pkts_dropped, overflow);
        obs_addr.delete(); obs_data.delete();
        ex_addr.delete();  ex_data.delete();
    endtask

    // One packet of len beats; err_beat (1-based, 0 = none) carries in_error.
    // match selects clear,inc_addr,clear versus clear,clear. foreign sends a
    // second packet's sop while the decision is pending.
    task automatic run_pkt(input string tag, input int len, input int err_beat,
                           input bit match, input bit foreign, input bit gaps);
        int start, free, beats, cap, nwr;
        bit trunc;
        logic [DW-1:0] d;
        start = m_commit;
        free  = (m_rd - start - 1 + 2 * N) % N;
        beats = (err_beat != 0) ? err_beat - 1 : len;
        cap   = (free > HDR) ? free - HDR : 0;
        nwr   = (beats < cap) ? beats : cap;
        trunc = (beats > cap);
        if (trunc) m_ovf = 1'b1;

        for (int k = 0; k < len; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
                idle_inputs();
                tick();
            end
            d        = $urandom;
            in_valid = 1'b1;
            in_sop   = (k == 0);
            in_eop   = (k == len - 1);
            in_error = (k + 1 == err_beat);
            in_data  = d;
            if (k < nwr) begin
                ex_addr.push_back((start + HDR + k) % N);
                ex_data.push_back(d);
            end
            tick();
            if (k + 1 == err_beat) break;
        end
        idle_inputs();

        if (err_beat != 0) begin
            m_dropped++;
        end else begin
            tick();
            clear = 1'b1;
            if (foreign) begin
                in_valid = 1'b1; in_sop = 1'b1; in_data = $urandom;
            end
            tick();
            idle_inputs();
            if (match) inc_addr = 1'b1;
            else       clear    = 1'b1;
            tick();
            idle_inputs();
            if (match) begin
                clear = 1'b1;
                tick();
                idle_inputs();
            end
            if (foreign) begin
                m_dropped++;
                in_valid = 1'b1; in_data = $urandom;
                tick();
                in_valid = 1'b1; in_eop = 1'b1; in_data = $urandom;
                tick();
                idle_inputs();
            end
            if (match && !trunc) begin
                if (HDR != 0) begin
                    ex_addr.push_back(start);
                    ex_data.push_back({16'hCAFE, 16'(len)});
                end
                m_commit = (start + HDR + len) % N;
                m_committed++;
            end else begin
                m_dropped++;
            end
        end
        tick(); tick();
        check_status(tag);
    endtask

    initial begin
        int len, err, backlog;
        idle_inputs();
        n_rst  = 1'b0;
        rd_ptr = '0;
        do_reset();

        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_commit_ptr", 64'(commit_ptr), 64'd0);
        check("rst_committed", 64'(pkts_committed), 64'd0);
        check("rst_dropped", 64'(pkts_dropped), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Match commits a 4-beat packet.
        run_pkt("commit4", 4, 0, 1'b1, 1'b0, 1'b0);

        // No match discards; the next packet reuses the same space.
        do_reset();
        run_pkt("nomatch4", 4, 0, 1'b0, 1'b0, 1'b0);
        run_pkt("after_nomatch", 2, 0, 1'b1, 1'b0, 1'b0);

        // Error on beat 3 of 5, then a clean packet from the same start.
        do_reset();
        run_pkt("err3of5", 5, 3, 1'b1, 1'b0, 1'b0);
        run_pkt("after_err", 3, 0, 1'b1, 1'b0, 1'b0);

        // Oversized packet on an empty ring truncates and is refused at commit.
        do_reset();
        run_pkt("overflow10", 10, 0, 1'b1, 1'b0, 1'b0);

        // Packet wraps past the top of the ring.
        do_reset();
        run_pkt("fill6", 6, 0, 1'b1, 1'b0, 1'b0);
        set_rd(5);
        run_pkt("wrap3", 3, 0, 1'b1, 1'b0, 1'b0);

        // A packet starting during the decision is drained and counted.
        do_reset();
        run_pkt("foreign", 3, 0, 1'b1, 1'b1, 1'b0);
        run_pkt("after_drain", 2, 0, 1'b1, 1'b0, 1'b0);

        // Randomised traffic, with the host reader trailing the commit pointer.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            backlog = (m_commit - m_rd + N) % N;
            set_rd(m_rd + $urandom_range(0, backlog));
            len = $urandom_range(1, 9);
            err = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len) : 0;
            run_pkt($sformatf("rand%0d", i), len, err, 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 5) == 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_capture_buffer.md
# pkt_capture_buffer

Downstream capture stage for the sniffer datapath: writes every packet arriving from the MAC stream into a circular capture memory, then commits or discards it according to the match controller's `clear`/`inc_addr` outputs. Committed packets stay readable by the host; unmatched, errored or overflowed packets are rolled back so their space is reused. Sits between the controller (and MAC stream) and the on-chip capture RAM / Avalon slave.

## Interface

- ADDR_W, 10, capture memory address width; ring holds 2^ADDR_W words
- DATA_W, 32, data word width
- clk  in  1  system clock
- n_rst  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  MAC stream beat valid
- in_sop  in  1  start of packet, qualified by in_valid
- in_eop  in  1  end of packet, qualified by in_valid
- in_error  in  1  MAC error, qualified by in_valid
- in_data  in  DATA_W  stream data
- clear  in  1  controller clear flag
- inc_addr  in  1  controller commit flag
- rd_ptr  in  ADDR_W  host read pointer (oldest unread word)
- mem_wr  out  1  capture RAM write strobe
- mem_addr  out  ADDR_W  capture RAM write address
- mem_wdata  out  DATA_W  capture RAM write data
- commit_ptr  out  ADDR_W  one past last committed word
- pkts_committed  out  32  committed packet count, wraps
- pkts_dropped  out  16  discarded packet count, saturates at 16'hFFFF
- overflow  out  1  sticky; set when a packet hit a full ring

## Operation

- States: IDLE, CAPTURE, PENDING, DECIDE, DRAIN.
- IDLE: in_valid & in_sop -> start_ptr <= wr_ptr; write beat; CAPTURE (or PENDING if in_eop same beat). Non-sop beats ignored.
- CAPTURE: each in_valid beat written at wr_ptr, wr_ptr += 1 mod 2^ADDR_W, len += 1. in_eop -> PENDING. in_error -> rollback (wr_ptr <= start_ptr), pkts_dropped += 1, IDLE; errored beat not written.
- Full: ring full when wr_ptr + 1 == rd_ptr. A beat arriving while full is not written; overflow <= 1; truncated flag set; remaining beats dropped, state CAPTURE until eop/error.
- PENDING: waits for controller. clear=1 -> DECIDE. inc_addr ignored here.
- DECIDE: inc_addr=1 and not truncated -> commit: commit_ptr <= wr_ptr, pkts_committed += 1, IDLE. Otherwise (clear=1 or inc_addr on truncated packet) -> rollback, pkts_dropped += 1, IDLE. Neither asserted -> stay.
- in_sop arriving in PENDING/DECIDE: that packet is not captured; DRAIN entered after decision if its eop not yet seen; DRAIN discards beats until in_eop, then IDLE; pkts_dropped += 1 for it.
- sop inside CAPTURE (missing eop): current packet rolled back and counted dropped; new packet starts in same cycle.
- Rollback never moves commit_ptr; committed data never overwritten (full check uses rd_ptr).

## Timing

- Reset values: mem_wr 0, mem_addr 0, mem_wdata 0, commit_ptr 0, pkts_committed 0, pkts_dropped 0, overflow 0; internal wr_ptr/start_ptr 0, state IDLE.
- mem_wr/mem_addr/mem_wdata registered: accepted beat at edge N appears on outputs during cycle N+1, one-cycle strobe.
- Commit/rollback take effect on the edge where DECIDE sees inc_addr/clear; commit_ptr valid next cycle.
- Controller sequence on match: clear (1 cycle), inc_addr (1 cycle), clear; on no match: clear, clear. Both handled by PENDING->DECIDE.
- Reset mid-packet: all state returns to reset values; partial packet lost, no count.

## Configuration

- PKT_CAPTURE_HEADER_EN defined: on sop, one word reserved at start_ptr (data starts at start_ptr+1; header counts toward full check). On commit, one header write issued the following cycle: mem_addr = start_ptr, mem_wdata = {16'hCAFE, len[15:0]} (len = data words, zero-extended/truncated to 16). commit_ptr updates same edge as header write.
- Undefined: no reserved word, no header write; data starts at start_ptr.

## Test plan

- Reset, 4-beat packet (sop..eop), controller clear then inc_addr -> mem_addr 0..3 written, commit_ptr 4, pkts_committed 1.
- Same packet, clear then clear -> commit_ptr stays 0, pkts_dropped 1, next packet written from address 0.
- Error on beat 3 of 5 -> rollback, pkts_dropped 1, no write for errored beat, IDLE.
- ADDR_W=3, rd_ptr=0, 10-beat packet -> 7 words written, overflow 1, inc_addr discarded, commit_ptr 0.
- wr_ptr=6, ADDR_W=3, rd_ptr=5, 3-beat packet committed -> addresses 6,7,0; commit_ptr 1.
- With PKT_CAPTURE_HEADER_EN, 2-beat packet committed -> data at 1,2; header 32'hCAFE0002 at 0; commit_ptr 3.
